// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM encoding, owner enum, width defaults.
// Optional feature macro used by this slice: ARB_ROUND_ROBIN_EN.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN defined: contention resolved by rr_next; otherwise data wins.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic rr_next,
`endif
  output logic grant,
  output logic owner
);

  always_comb begin
    grant = i_req | d_req;
    owner = OWN_I;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      owner = rr_next;
`else
      owner = OWN_D;
`endif
    end else if (d_req) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch and data requesters.
// ARB_ROUND_ROBIN_EN selects alternating grants under contention.
//
// state | meaning
// IDLE  | no transaction; pick a winner and latch mem_* when any req pending
// ISSUE | address/strobe presented; memory samples at the closing edge
// RESP  | mem_rdata valid; ack the owner, capture read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e              state, state_nxt;
  owner_e              owner;
  logic                txn_we;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;
  logic                pick_grant;
  logic                pick_owner;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_next;
`endif

  arb_pick u_arb_pick (
    .i_req   (i_req),
    .d_req   (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_next (rr_next),
`endif
    .grant   (pick_grant),
    .owner   (pick_owner)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_I;
      txn_we    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (pick_grant) begin
          owner <= owner_e'(pick_owner);
          if (owner_e'(pick_owner) == OWN_D) begin
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
            txn_we    <= d_we;
          end else begin
            mem_addr <= i_addr;
            mem_we   <= 1'b0;
            txn_we   <= 1'b0;
          end
        end
        ISSUE: mem_we <= 1'b0;
        RESP: begin
          if (owner == OWN_I)  i_rdata_q <= mem_rdata;
          else if (!txn_we)    d_rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Pointer only moves on grants made while both ports were requesting.
  always_ff @(posedge clk) begin
    if (rst)
      rr_next <= OWN_I;
    else if (state == IDLE && i_req && d_req)
      rr_next <= ~pick_owner;
  end
`endif

  // Ack is suppressed while rst is high so a reset in RESP never acknowledges.
  assign i_ack   = (state == RESP) && (owner == OWN_I) && !rst;
  assign d_ack   = (state == RESP) && (owner == OWN_D) && !rst;
  assign i_rdata = i_ack ? mem_rdata : i_rdata_q;
  assign d_rdata = (d_ack && !txn_we) ? mem_rdata : d_rdata_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 1024x32 sync-read memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [9:0]  i_addr, d_addr;
  logic [31:0] d_wdata;
  logic        i_ack, d_ack, busy, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem [1024];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (rst) mem[0] <= 32'h2406_0014;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;

    // fetch read of word 0
    i_req = 1'b1; i_addr = 10'd0;
    step();
    check("f_busy", busy, 1);
    check("f_early_ack", i_ack, 0);
    check("f_mem_addr", mem_addr, 0);
    step();
    check("f_i_ack", i_ack, 1);
    check("f_d_ack", d_ack, 0);
    check("f_i_rdata", i_rdata, 32'h2406_0014);
    i_req = 1'b0;
    step();
    check("f_ack_pulse", i_ack, 0);
    check("f_idle", busy, 0);
    check("f_rdata_hold", i_rdata, 32'h2406_0014);

    // data write to top address
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_wdata = 32'hDEAD_BEEF;
    step();
    check("w_mem_we", mem_we, 1);
    check("w_mem_addr", mem_addr, 10'h3FF);
    check("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    check("w_mem_we_drop", mem_we, 0);
    check("w_d_ack", d_ack, 1);
    check("w_i_ack", i_ack, 0);
    check("w_d_rdata_kept", d_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("w_idle", busy, 0);
    check("w_mem_we_idle", mem_we, 0);

    // data read back
    d_req = 1'b1;
    step();
    check("r_mem_we", mem_we, 0);
    step();
    check("r_d_ack", d_ack, 1);
    check("r_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    step();
    check("r_ack_pulse", d_ack, 0);
    check("r_rdata_hold", d_rdata, 32'hDEAD_BEEF);

`ifndef ARB_ROUND_ROBIN_EN
    // contention, fixed priority: data first, fetch at +5
    i_req = 1'b1; i_addr = 10'd0; d_req = 1'b1; d_addr = 10'h3FF;
    step();
    check("c_mem_addr_d", mem_addr, 10'h3FF);
    step();
    check("c_d_ack", d_ack, 1);
    check("c_i_ack_n2", i_ack, 0);
    d_req = 1'b0;
    step();
    check("c_i_ack_n3", i_ack, 0);
    step();
    check("c_mem_addr_i", mem_addr, 0);
    check("c_i_ack_n4", i_ack, 0);
    step();
    check("c_i_ack_n5", i_ack, 1);
    check("c_d_ack_n5", d_ack, 0);
    check("c_i_rdata", i_rdata, 32'h2406_0014);
    i_req = 1'b0;
    step();
`else
    // contention, round robin: winners fetch, data, fetch
    for (int r = 0; r < 3; r++) begin
      i_req = 1'b1; i_addr = 10'd0; d_req = 1'b1; d_addr = 10'h3FF;
      step();
      step();
      check("rr_first_i", i_ack, (r == 1) ? 0 : 1);
      check("rr_first_d", d_ack, (r == 1) ? 1 : 0);
      if (r == 1) d_req = 1'b0;
      else        i_req = 1'b0;
      step();
      step();
      step();
      check("rr_second_i", i_ack, (r == 1) ? 1 : 0);
      check("rr_second_d", d_ack, (r == 1) ? 0 : 1);
      i_req = 1'b0; d_req = 1'b0;
      step();
    end
`endif

    // reset while a fetch is in ISSUE
    i_req = 1'b1; i_addr = 10'd5;
    step();
    check("ri_busy", busy, 1);
    rst = 1'b1;
    step();
    check("ri_busy_cleared", busy, 0);
    check("ri_no_ack", i_ack, 0);
    check("ri_mem_addr", mem_addr, 0);
    check("ri_i_rdata", i_rdata, 0);
    check("ri_d_rdata", d_rdata, 0);
    rst = 1'b0;
    i_addr = 10'd0;
    step();
    check("ri_reissue_busy", busy, 1);
    check("ri_reissue_early", i_ack, 0);
    step();
    check("ri_reissue_ack", i_ack, 1);
    check("ri_reissue_rdata", i_rdata, 32'h2406_0014);
    i_req = 1'b0;
    step();

    // idle bus
    for (int k = 0; k < 10; k++) begin
      step();
      check("idle_busy", busy, 0);
      check("idle_mem_we", mem_we, 0);
      check("idle_i_ack", i_ack, 0);
      check("idle_d_ack", d_ack, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
